// File: rtl/hdb3_encoder.sv
// HDB3 line encoder: AMI marking with 000V / B00V substitution of four-zero runs.
// A 4-deep tag pipeline provides the look-ahead needed to retag the first zero of a run as B.
module hdb3_encoder (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  input  logic en,
  output logic bp,
  output logic bn
);

  typedef enum logic [1:0] {
    TAG_ZERO = 2'd0,
    TAG_ONE  = 2'd1,
    TAG_BSUB = 2'd2,
    TAG_VIOL = 2'd3
  } tag_t;

  tag_t       r_stg0, r_stg1, r_stg2, r_stg3;
  logic [1:0] r_zero_cnt;
  logic       r_parity;
  logic       r_last_pos;

  logic       w_fourth_zero;
  tag_t       w_new_tag;
  tag_t       w_stg3_next;
  logic       w_is_b;
  logic       w_is_v;
  logic       w_pos;
  logic       w_bp_next;
  logic       w_bn_next;
  logic [1:0] w_zero_cnt_next;
  logic       w_parity_next;
  logic       w_last_pos_next;

  // Input stage: classify the incoming bit and decide on a substitution.
  always_comb begin
    w_fourth_zero   = ~data_in & (r_zero_cnt == 2'd3);
    w_new_tag       = TAG_ZERO;
    w_zero_cnt_next = r_zero_cnt;
    w_parity_next   = r_parity;
    if (data_in) begin
      w_new_tag       = TAG_ONE;
      w_zero_cnt_next = 2'd0;
      w_parity_next   = ~r_parity;
    end else if (w_fourth_zero) begin
      w_new_tag       = TAG_VIOL;
      w_zero_cnt_next = 2'd0;
      w_parity_next   = 1'b0;
    end else begin
      w_new_tag       = TAG_ZERO;
      w_zero_cnt_next = r_zero_cnt + 2'd1;
    end
  end

  // With an even count of B marks since the last V, the oldest zero becomes B.
  always_comb begin
    w_stg3_next = r_stg2;
    if (w_fourth_zero && !r_parity) begin
      w_stg3_next = TAG_BSUB;
    end
  end

  // Output stage: B-type marks alternate polarity, V repeats the previous one.
  always_comb begin
    w_is_b          = (r_stg3 == TAG_ONE) || (r_stg3 == TAG_BSUB);
    w_is_v          = (r_stg3 == TAG_VIOL);
    w_pos           = w_is_b ? ~r_last_pos : r_last_pos;
    w_bp_next       = en & (w_is_b | w_is_v) & w_pos;
    w_bn_next       = en & (w_is_b | w_is_v) & ~w_pos;
    w_last_pos_next = w_is_b ? ~r_last_pos : r_last_pos;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_stg0     <= TAG_ZERO;
      r_stg1     <= TAG_ZERO;
      r_stg2     <= TAG_ZERO;
      r_stg3     <= TAG_ZERO;
      r_zero_cnt <= 2'd0;
      r_parity   <= 1'b0;
      r_last_pos <= 1'b0;
      bp         <= 1'b0;
      bn         <= 1'b0;
    end else begin
      bp <= w_bp_next;
      bn <= w_bn_next;
      if (en) begin
        r_stg0     <= w_new_tag;
        r_stg1     <= r_stg0;
        r_stg2     <= r_stg1;
        r_stg3     <= w_stg3_next;
        r_zero_cnt <= w_zero_cnt_next;
        r_parity   <= w_parity_next;
        r_last_pos <= w_last_pos_next;
      end
    end
  end

endmodule

// File: tb/tb_hdb3_encoder.sv
// Self-checking bench for hdb3_encoder: directed vectors plus randomized stream
// compared against a queue-based symbol model.
module tb_hdb3_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic data_in = 1'b0;
  logic en = 1'b0;
  logic bp, bn;

  int n_tests = 0;
  int n_fail = 0;

  localparam int T_ZERO = 0;
  localparam int T_ONE  = 1;
  localparam int T_B    = 2;
  localparam int T_V    = 3;

  int mq[$];
  int m_run;
  bit m_par;
  int m_pol;

  hdb3_encoder dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .en(en), .bp(bp), .bn(bn)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] code(input int p);
    if (p > 0) return 2'b10;
    if (p < 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    mq.delete();
    repeat (4) mq.push_back(T_ZERO);
    m_run = 0;
    m_par = 1'b0;
    m_pol = -1;
  endtask

  // Symbols sit in a 4-entry queue; a symbol leaves when a new bit arrives.
  task automatic model_step(input bit d, input bit e, output int y);
    int t;
    y = 0;
    if (e) begin
      t = mq.pop_front();
      if (t == T_ONE || t == T_B) begin
        m_pol = -m_pol;
        y = m_pol;
      end else if (t == T_V) begin
        y = m_pol;
      end
      if (d) begin
        mq.push_back(T_ONE);
        m_run = 0;
        m_par = ~m_par;
      end else if (m_run == 3) begin
        if (!m_par) mq[mq.size()-3] = T_B;
        mq.push_back(T_V);
        m_run = 0;
        m_par = 1'b0;
      end else begin
        mq.push_back(T_ZERO);
        m_run++;
      end
    end
  endtask

  task automatic tick(input bit d, input bit e, input bit r);
    rst_n = r;
    data_in = d;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input string name, input bit din[], input int exp[]);
    int y;
    bit d;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      n_tests++;
      if ({bp, bn} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s_reset: bp/bn=%b expected 00", name, {bp, bn});
      end
    end
    model_reset();
    for (int i = 0; i < din.size() + 4; i++) begin
      d = (i < din.size()) ? din[i] : 1'b0;
      tick(d, 1'b1, 1'b0);
      model_step(d, 1'b1, y);
      n_tests++;
      if ({bp, bn} !== code(y)) begin
        n_fail++;
        $display("FAIL %s_model cyc %0d: bp/bn=%b expected %b", name, i, {bp, bn}, code(y));
      end
      if (i < 4) begin
        n_tests++;
        if ({bp, bn} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s_latency cyc %0d: bp/bn=%b expected 00", name, i, {bp, bn});
        end
      end else begin
        n_tests++;
        if ({bp, bn} !== code(exp[i-4])) begin
          n_fail++;
          $display("FAIL %s_vec sym %0d: bp/bn=%b expected %b", name, i-4, {bp, bn}, code(exp[i-4]));
        end
      end
    end
  endtask

  task automatic test_reset();
    int y;
    for (int i = 0; i < 5; i++) begin
      tick(i[0], 1'b1, 1'b1);
      n_tests++;
      if ({bp, bn} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: bp/bn=%b expected 00", i, {bp, bn});
      end
    end
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      model_step(1'b1, 1'b1, y);
      n_tests++;
      if (i < 4 && {bp, bn} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_first4 cyc %0d: bp/bn=%b expected 00", i, {bp, bn});
      end else if (i >= 4 && {bp, bn} !== code(y)) begin
        n_fail++;
        $display("FAIL reset_ami cyc %0d: bp/bn=%b expected %b", i, {bp, bn}, code(y));
      end
    end
  endtask

  task automatic test_basic_ami();
    bit din[];
    int exp[];
    din = '{1, 1, 1, 0, 1};
    exp = '{1, -1, 1, 0, -1};
    run_directed("ami", din, exp);
  endtask

  task automatic test_b00v();
    bit din[];
    int exp[];
    din = '{1, 1, 0, 0, 0, 0, 1};
    exp = '{1, -1, 1, 0, 0, 1, -1};
    run_directed("b00v", din, exp);
  endtask

  task automatic test_000v();
    bit din[];
    int exp[];
    din = '{1, 0, 0, 0, 0, 1};
    exp = '{1, 0, 0, 0, 1, -1};
    run_directed("000v", din, exp);
  endtask

  task automatic test_long_zero_run();
    bit din[];
    int exp[];
    din = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp = '{1, 0, 0, 0, 1, -1, 0, 0, -1, 1};
    run_directed("long_run", din, exp);
  endtask

  task automatic test_en_gap();
    bit stream[];
    int y;
    stream = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    tick(1'b0, 1'b0, 1'b1);
    model_reset();
    for (int i = 0; i < stream.size(); i++) begin
      if (i == 6) begin
        for (int g = 0; g < 3; g++) begin
          tick(~stream[i], 1'b0, 1'b0);
          model_step(~stream[i], 1'b0, y);
          n_tests++;
          if ({bp, bn} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_gap_idle cyc %0d: bp/bn=%b expected 00", g, {bp, bn});
          end
        end
      end
      tick(stream[i], 1'b1, 1'b0);
      model_step(stream[i], 1'b1, y);
      n_tests++;
      if ({bp, bn} !== code(y)) begin
        n_fail++;
        $display("FAIL en_gap_stream bit %0d: bp/bn=%b expected %b", i, {bp, bn}, code(y));
      end
    end
  endtask

  task automatic test_midstream_reset();
    bit din[];
    int exp[];
    for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    din = '{1, 1, 0, 0, 0, 0, 1};
    exp = '{1, -1, 1, 0, 0, 1, -1};
    run_directed("mid_reset", din, exp);
  endtask

  task automatic test_random();
    int y;
    bit d, e;
    int prev_pol, b_cnt;
    bit seen_v;
    tick(1'b0, 1'b0, 1'b1);
    model_reset();
    prev_pol = -1;
    b_cnt = 0;
    seen_v = 1'b0;
    for (int i = 0; i < 800; i++) begin
      d = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 7) != 0);
      tick(d, e, 1'b0);
      model_step(d, e, y);
      n_tests++;
      if ({bp, bn} !== code(y)) begin
        n_fail++;
        $display("FAIL random cyc %0d: bp/bn=%b expected %b", i, {bp, bn}, code(y));
      end
      if (bp === 1'b1 || bn === 1'b1) begin
        if ((bp ? 1 : -1) == prev_pol) begin
          if (seen_v) begin
            n_tests++;
            if (b_cnt % 2 != 1) begin
              n_fail++;
              $display("FAIL random_v_to_v cyc %0d: B count=%0d expected odd", i, b_cnt);
            end
          end
          seen_v = 1'b1;
          b_cnt = 0;
        end else begin
          b_cnt++;
        end
        prev_pol = bp ? 1 : -1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ami();
    test_b00v();
    test_000v();
    test_long_zero_run();
    test_en_gap();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
